regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two-requester arbiter in front of a single register-file write port.
//   Requester 0 (ALU) has fixed priority; requester 1 (load unit) gains
//   priority once it has lost STARVE_MAX consecutive contested cycles.
//   The winning request is captured and presented as a registered write
//   (wEnable/dR/wData) in the cycle after the transfer edge.
//
//   Optional feature: define REG0_GUARD_EN to suppress the register-file
//   write for transfers targeting index 0 (the transfer is still accepted).
//
// Ports:
//   clk         clock, all state on posedge
//   rst         asynchronous active-high reset
//   req0_valid  ALU writeback request
//   req0_dR     ALU destination index
//   req0_data   ALU write data
//   req0_ready  grant to requester 0 (combinational)
//   req1_valid  load-unit writeback request
//   req1_dR     load-unit destination index
//   req1_data   load-unit write data
//   req1_ready  grant to requester 1 (combinational)
//   wEnable     registered register-file write enable
//   dR          registered register-file write index
//   wData       registered register-file write data
//   starved     high while the starvation counter equals STARVE_MAX
module regfile_write_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_dR,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_dR,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        wEnable,
    output logic [4:0]  dR,
    output logic [31:0] wData,
    output logic        starved
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0]  starveCnt;
    logic        xfer0;
    logic        xfer1;
    logic        anyXfer;
    logic        writeNow;
    logic [4:0]  selDR;
    logic [31:0] selData;

    assign starved = (starveCnt == STARVE_LIMIT);

    // Requester 1 wins when alone or when starved; requester 0 wins otherwise.
    // Both grants are held low during reset so nothing transfers until the
    // first edge after release.
    always_comb begin
        req1_ready = 1'b0;
        req0_ready = 1'b0;
        if (!rst) begin
            req1_ready = req1_valid && (!req0_valid || starved);
            req0_ready = req0_valid && !(req1_valid && starved);
        end
    end

    always_comb begin
        xfer0   = req0_valid && req0_ready;
        xfer1   = req1_valid && req1_ready;
        anyXfer = xfer0 || xfer1;
        selDR   = xfer1 ? req1_dR   : req0_dR;
        selData = xfer1 ? req1_data : req0_data;
`ifdef REG0_GUARD_EN
        writeNow = anyXfer && (selDR != '0);
`else
        writeNow = anyXfer;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wEnable   <= 1'b0;
            dR        <= '0;
            wData     <= '0;
            starveCnt <= '0;
        end else begin
            wEnable <= writeNow;
            if (anyXfer) begin
                dR    <= selDR;
                wData <= selData;
            end
            // Counter only tracks an uninterrupted run of lost cycles.
            if (!req1_valid || xfer1) begin
                starveCnt <= '0;
            end else if (starveCnt != STARVE_LIMIT) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_dR;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_dR;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wEnable;
    logic [4:0]  dR;
    logic [31:0] wData;
    logic        starved;

    int tests;
    int fails;

    regfile_write_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dR    (req0_dR),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dR    (req1_dR),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wEnable    (wEnable),
        .dR         (dR),
        .wData      (wData),
        .starved    (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req0_valid = 1'b0;
        req0_dR    = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_dR    = '0;
        req1_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        #1;
        tests++;
        if (wEnable !== 1'b0 || dR !== 5'd0 || wData !== 32'd0 || starved !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got wEnable=%b dR=%0d wData=%h starved=%b, want 0 0 00000000 0",
                     wEnable, dR, wData, starved);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || wEnable !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got r0=%b r1=%b wEnable=%b, want 0 0 0",
                     req0_ready, req1_ready, wEnable);
        end
        idleInputs();
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_single_req0();
        req0_valid = 1'b1;
        req0_dR    = 5'd5;
        req0_data  = 32'h1234_5678;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_ready: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        step();
        idleInputs();
        tests++;
        if (wEnable !== 1'b1 || dR !== 5'd5 || wData !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_write: got wEnable=%b dR=%0d wData=%h, want 1 5 12345678",
                     wEnable, dR, wData);
        end
        step();
        tests++;
        if (wEnable !== 1'b0 || dR !== 5'd5 || wData !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_hold: got wEnable=%b dR=%0d wData=%h, want 0 5 12345678",
                     wEnable, dR, wData);
        end
    endtask

    // Both valid continuously: req0 wins four cycles, req1 wins the fifth.
    task automatic test_starvation();
        logic expR0;
        logic expSt;
        req0_valid = 1'b1; req0_dR = 5'd1; req0_data = 32'hAAAA_0001;
        req1_valid = 1'b1; req1_dR = 5'd2; req1_data = 32'hBBBB_0002;
        for (int i = 1; i <= 5; i++) begin
            expR0 = (i < 5);
            expSt = (i == 5);
            #1;
            tests++;
            if (req0_ready !== expR0 || req1_ready !== !expR0 || starved !== expSt) begin
                fails++;
                $display("FAIL starve_grant cycle %0d: got r0=%b r1=%b starved=%b, want %b %b %b",
                         i, req0_ready, req1_ready, starved, expR0, !expR0, expSt);
            end
            step();
            tests++;
            if (wEnable !== 1'b1 || dR !== (expR0 ? 5'd1 : 5'd2) ||
                wData !== (expR0 ? 32'hAAAA_0001 : 32'hBBBB_0002)) begin
                fails++;
                $display("FAIL starve_write cycle %0d: got wEnable=%b dR=%0d wData=%h, want 1 %0d %h",
                         i, wEnable, dR, wData, expR0 ? 1 : 2,
                         expR0 ? 32'hAAAA_0001 : 32'hBBBB_0002);
            end
        end
        tests++;
        if (starved !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL starve_clear: got starved=%b r0=%b r1=%b, want 0 1 0",
                     starved, req0_ready, req1_ready);
        end
        idleInputs();
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  dRs   [3];
        logic [31:0] datas [3];
        dRs[0] = 5'd3;  datas[0] = 32'hC0DE_0000;
        dRs[1] = 5'd4;  datas[1] = 32'hC0DE_1111;
        dRs[2] = 5'd31; datas[2] = 32'hC0DE_2222;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1;
            req1_dR    = dRs[i];
            req1_data  = datas[i];
            #1;
            tests++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ready %0d: got r1=%b r0=%b, want 1 0", i, req1_ready, req0_ready);
            end
            step();
            tests++;
            if (wEnable !== 1'b1 || dR !== dRs[i] || wData !== datas[i]) begin
                fails++;
                $display("FAIL b2b_write %0d: got wEnable=%b dR=%0d wData=%h, want 1 %0d %h",
                         i, wEnable, dR, wData, dRs[i], datas[i]);
            end
        end
        idleInputs();
        step();
        tests++;
        if (wEnable !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got wEnable=%b, want 0", wEnable);
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1;
        req0_dR    = 5'd7;
        req0_data  = 32'hDEAD_BEEF;
        step();
        tests++;
        if (wEnable !== 1'b1 || dR !== 5'd7) begin
            fails++;
            $display("FAIL rstmid_pending: got wEnable=%b dR=%0d, want 1 7", wEnable, dR);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (wEnable !== 1'b0 || dR !== 5'd0 || wData !== 32'd0 || req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: got wEnable=%b dR=%0d wData=%h r0=%b, want 0 0 00000000 0",
                     wEnable, dR, wData, req0_ready);
        end
        idleInputs();
        step();
        #2 rst = 1'b0;
        step();
        tests++;
        if (wEnable !== 1'b0 || dR !== 5'd0) begin
            fails++;
            $display("FAIL rstmid_release: got wEnable=%b dR=%0d, want 0 0", wEnable, dR);
        end
    endtask

    task automatic test_reg0();
        logic expWe;
`ifdef REG0_GUARD_EN
        expWe = 1'b0;
`else
        expWe = 1'b1;
`endif
        req0_valid = 1'b1;
        req0_dR    = 5'd0;
        req0_data  = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL reg0_ready: got r0=%b, want 1", req0_ready);
        end
        step();
        idleInputs();
        tests++;
        if (wEnable !== expWe || dR !== 5'd0) begin
            fails++;
            $display("FAIL reg0_write: got wEnable=%b dR=%0d, want %b 0", wEnable, dR, expWe);
        end
        step();
    endtask

    // Two lost cycles, then req1 drops for one cycle: the counter restarts,
    // so req0 wins four more contested cycles before req1 gets priority.
    task automatic test_counter_clear();
        logic expR0;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_dR = 5'd9;  req0_data = 32'h0000_0009;
            req1_valid = (i != 2); req1_dR = 5'd10; req1_data = 32'h0000_000A;
            // cycles 0,1 contested; 2 req1 absent; 3..6 req0; 7 req1
            expR0 = (i < 7);
            #1;
            tests++;
            if (req0_ready !== expR0 || req1_ready !== (req1_valid && !expR0)) begin
                fails++;
                $display("FAIL cntclr cycle %0d: got r0=%b r1=%b, want %b %b",
                         i, req0_ready, req1_ready, expR0, req1_valid && !expR0);
            end
            step();
        end
        idleInputs();
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_req0();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_reg0();
        test_counter_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
